fft_stage1_butterfly: RTL
=========================

// Module: fft_stage1_butterfly
// PURPOSE
//  Downstream of the ADC SPI capture and 8-sample shift stage.
//  - Collects 8 consecutive ADC samples into a frame.
//  - Computes the first radix-2 DIT butterfly layer of the 8-point FFT, one pair per beat:
//    sum = x[k]+x[k+4], diff = x[k]-x[k+4], k = 0..3.
//  - Presents results on a valid/ready stream to later FFT stages.
//  - Double-buffered: the next frame is collected while the current one drains.
// PARAMETERS
//  DW        16  sample width in bits
//  SIGNED_IN 1   1: SAMPLE_IN is two's complement; 0: offset binary, MSB inverted on capture
// PORTS
//  CLK          in   1     system clock (16 MHz), all logic on rising edge
//  RST_N        in   1     asynchronous reset, active low
//  SAMPLE_IN    in   DW    ADC sample, qualified by SAMPLE_VALID
//  SAMPLE_VALID in   1     one-cycle strobe (ADC DV); no backpressure, always accepted
//  OUT_SUM      out  DW+1  x[k]+x[k+4], signed
//  OUT_DIFF     out  DW+1  x[k]-x[k+4], signed
//  OUT_IDX      out  2     butterfly index k
//  OUT_LAST     out  1     high while OUT_IDX==3
//  OUT_VALID    out  1     result beat valid
//  OUT_READY    in   1     consumer accepts the beat when OUT_VALID&OUT_READY
//  BUSY         out  1     compute bank holds a frame not yet fully drained
//  OVERRUN      out  1     one-cycle pulse: completed frame dropped
//  FILL_CNT     out  3     samples in the collect bank (0..7)
// BEHAVIOUR
//  Reset (async, RST_N=0): all outputs 0, FILL_CNT=0, FSM=IDLE, both banks cleared.
//  - Reset mid-frame or mid-drain discards all data; no beat is emitted after release.
//  Collect:
//  - Each SAMPLE_VALID writes the collect bank at FILL_CNT; x[0] is the first sample.
//  - FILL_CNT wraps 7->0 on the 8th sample (frame complete), whatever the handoff result.
//  Handoff on frame complete:
//  - Compute bank free (IDLE, or last beat handshaking that same cycle): frame is copied to
//    the compute bank; FSM -> RUN, k=0.
//  - Otherwise: frame dropped, OVERRUN=1 for that cycle, compute bank untouched.
//  FSM IDLE/RUN:
//  - RUN: OUT_VALID=1, BUSY=1.
//  - On OUT_VALID&OUT_READY: k=k+1. At k==3 go to IDLE, unless a simultaneous handoff
//    restarts RUN with k=0.
//  - !OUT_READY: OUT_SUM/OUT_DIFF/OUT_IDX/OUT_LAST hold stable.
//  Latency: the 8th strobe at edge t gives OUT_VALID=1, k=0 after edge t+1 (registered).
//  - With OUT_READY held 1, beats k=0..3 on 4 consecutive cycles.
//  Arithmetic:
//  - Operands sign-extended to DW+1; full precision, no overflow possible.
//  - SIGNED_IN=0: sample MSB inverted before storage (0x8000 -> 0, 0x0000 -> -32768).
//  - Outputs are registered; combinational paths from OUT_READY to OUT_VALID are not allowed.
// CONFIGURATION
//  Macro FFT_BF_SCALE_EN:
//  - Defined: OUT_SUM/OUT_DIFF = full result >>> 1 (arithmetic), sign-extended into DW+1
//    bits, so the magnitude stays within DW bits. Truncation only, no rounding.
//  - Undefined: full-precision DW+1 results.
//  - Timing and handshake are identical in both builds.
// TESTING
//  T1 SIGNED_IN=1, samples 1..8 back-to-back, OUT_READY=1
//     -> beats k0..3: SUM=6,8,10,12; DIFF=-4 each; OUT_LAST only on k3.
//  T2 all 8 samples 0x7FFF
//     -> SUM=0x0FFFE, DIFF=0 (17-bit).
//     With FFT_BF_SCALE_EN: SUM=0x07FFF, DIFF=0.
//  T3 OUT_READY=0 for 5 cycles after first OUT_VALID
//     -> k=0 data stable the whole time; then 4 beats in order, no loss or duplication.
//  T4 frame 2 completes while OUT_READY=0 holds frame 1 at k=1
//     -> OVERRUN pulses once, frame 1 beats unchanged, FILL_CNT=0.
//     Frame 2 completing on the same cycle as the k=3 handshake -> accepted, no OVERRUN.
//  T5 SIGNED_IN=0, x[0]=0xFFFF, x[4]=0x0000
//     -> k0 SUM=-1, DIFF=65535.
//  T6 RST_N pulsed low at FILL_CNT=5, and again during RUN at k=2
//     -> outputs 0 at once; after release the next 8 samples form a fresh frame.

Source files
------------

// File: rtl/fft_stage1_butterfly.sv
// First radix-2 DIT butterfly layer of an 8-point FFT with double-buffered frame capture.
// Optional FFT_BF_SCALE_EN halves every butterfly result (arithmetic shift, truncating).
module fft_stage1_butterfly #(
    parameter int DW        = 16,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] SAMPLE_IN,
    input  logic          SAMPLE_VALID,
    output logic [DW:0]   OUT_SUM,
    output logic [DW:0]   OUT_DIFF,
    output logic [1:0]    OUT_IDX,
    output logic          OUT_LAST,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          BUSY,
    output logic          OVERRUN,
    output logic [2:0]    FILL_CNT
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [DW-1:0] r_coll [8];
    logic [DW-1:0] r_comp [8];
    logic [2:0]    r_fill;
    logic [1:0]    r_k;
    logic [1:0]    w_k_nx;
    logic          r_start;
    logic          r_ovr;
    logic          r_busy;
    logic          r_last;
    logic [DW:0]   r_sum;
    logic [DW:0]   r_diff;

    logic [DW-1:0] w_samp;
    logic          w_hs;
    logic          w_done;
    logic          w_free;
    logic          w_take;
    logic          w_drop;
    logic          w_load;
    logic          w_clr;
    logic [1:0]    w_bk;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW+1:0] w_fs;
    logic [DW+1:0] w_fd;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;

    // Offset-binary samples become two's complement by flipping the MSB
    assign w_samp = SIGNED_IN ? SAMPLE_IN
                              : {~SAMPLE_IN[DW-1], SAMPLE_IN[DW-2:0]};

    assign w_hs   = (r_state == S_RUN) && OUT_READY;
    assign w_done = SAMPLE_VALID && (r_fill == 3'd7);
    assign w_free = ((r_state == S_IDLE) && !r_start)
                  || (w_hs && (r_k == 2'd3));
    assign w_take = w_done && w_free;
    assign w_drop = w_done && !w_free;

    // Operand pair for the beat about to be loaded into the output registers
    assign w_bk = r_start ? 2'd0 : r_k + 2'd1;
    assign w_a  = r_comp[{1'b0, w_bk}];
    assign w_b  = r_comp[{1'b1, w_bk}];
    assign w_fs = {{2{w_a[DW-1]}}, w_a} + {{2{w_b[DW-1]}}, w_b};
    assign w_fd = {{2{w_a[DW-1]}}, w_a} - {{2{w_b[DW-1]}}, w_b};

`ifdef FFT_BF_SCALE_EN
    assign w_sum  = w_fs[DW+1:1];
    assign w_diff = w_fd[DW+1:1];
`else
    assign w_sum  = w_fs[DW:0];
    assign w_diff = w_fd[DW:0];
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fill  <= 3'd0;
            r_start <= 1'b0;
            r_ovr   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_coll[i] <= '0;
                r_comp[i] <= '0;
            end
        end else begin
            r_start <= w_take;
            r_ovr   <= w_drop;
            if (SAMPLE_VALID) begin
                r_coll[r_fill] <= w_samp;
                r_fill         <= r_fill + 3'd1;
            end
            // The 8th sample bypasses the collect bank straight into the copy
            if (w_take) begin
                for (int i = 0; i < 7; i++) begin
                    r_comp[i] <= r_coll[i];
                end
                r_comp[7] <= w_samp;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_k_nx     = r_k;
        w_load     = 1'b0;
        w_clr      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_start) begin
                    w_state_nx = S_RUN;
                    w_k_nx     = 2'd0;
                    w_load     = 1'b1;
                end
            end
            S_RUN: begin
                if (OUT_READY) begin
                    if (r_k == 2'd3) begin
                        w_state_nx = S_IDLE;
                        w_k_nx     = 2'd0;
                        w_clr      = 1'b1;
                    end else begin
                        w_k_nx = r_k + 2'd1;
                        w_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_k_nx     = 2'd0;
                w_clr      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
            r_sum   <= '0;
            r_diff  <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_k     <= w_k_nx;
            r_busy  <= (w_state_nx == S_RUN) || w_take;
            if (w_load) begin
                r_sum  <= w_sum;
                r_diff <= w_diff;
                r_last <= (w_k_nx == 2'd3);
            end else if (w_clr) begin
                r_sum  <= '0;
                r_diff <= '0;
                r_last <= 1'b0;
            end
        end
    end

    assign OUT_SUM   = r_sum;
    assign OUT_DIFF  = r_diff;
    assign OUT_IDX   = r_k;
    assign OUT_LAST  = r_last;
    assign OUT_VALID = (r_state == S_RUN);
    assign BUSY      = r_busy;
    assign OVERRUN   = r_ovr;
    assign FILL_CNT  = r_fill;

endmodule
